// File: rtl/updown_counter_param_pkg.sv
// Shared definitions for the parametrised up/down counter: mode codes,
// ping-pong direction states and the load clamp helper.
package updown_counter_param_pkg;

    // Mode select encodings for the counter's mode input.
    localparam logic [1:0] MODE_DOWN     = 2'b00;
    localparam logic [1:0] MODE_UP       = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    // Ping-pong FSM states; the state register is dir_up itself.
    localparam logic ST_DOWN = 1'b0;
    localparam logic ST_UP   = 1'b1;

    typedef logic [1:0] mode_t;

    // Clamp a value into the inclusive range [lo, hi].
    function automatic int unsigned clamp_bound(
        input int unsigned value,
        input int unsigned lo,
        input int unsigned hi
    );
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/updown_counter_param_next_calc.sv
// Combinational next-state calculation for the up/down counter.
// Covers counting in all modes; load, reset, enable and hold priority
// are resolved by the top level.
module updown_next_calc
    import updown_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic [WIDTH-1:0] number,
    input  logic [1:0]       mode,
    input  logic             dir_up,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] next_number,
    output logic             next_dir,
    output logic             wrap_next,
    output logic             sat_next
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    // Bounds are tested before any +/-1 so the arithmetic never overflows.
    always_comb begin
        next_number = number;
        next_dir    = dir_up;
        wrap_next   = 1'b0;
        sat_next    = 1'b0;
        case (mode)
            MODE_UP: begin
                next_dir = ST_UP;
                if (number < MAX_V) begin
                    next_number = number + ONE;
                end else if (wrap_en) begin
                    next_number = MIN_V;
                    wrap_next   = 1'b1;
                end else begin
                    sat_next = 1'b1;
                end
            end
            MODE_DOWN: begin
                next_dir = ST_DOWN;
                if (number > MIN_V) begin
                    next_number = number - ONE;
                end else if (wrap_en) begin
                    next_number = MAX_V;
                    wrap_next   = 1'b1;
                end else begin
                    sat_next = 1'b1;
                end
            end
            MODE_PINGPONG: begin
                case (dir_up)
                    ST_UP: begin
                        if (number < MAX_V) begin
                            next_number = number + ONE;
                        end else begin
                            next_number = MAX_V - ONE;
                            next_dir    = ST_DOWN;
                            wrap_next   = 1'b1;
                        end
                    end
                    default: begin
                        if (number > MIN_V) begin
                            next_number = number - ONE;
                        end else begin
                            next_number = MIN_V + ONE;
                            next_dir    = ST_UP;
                            wrap_next   = 1'b1;
                        end
                    end
                endcase
            end
            default: begin
                next_number = number;
            end
        endcase
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, enable, wrap/saturate select
// and ping-pong mode. Holds the registers, priority and flag compares.
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             wrap_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] number,
    output logic             dir_up,
    output logic             zero,
    output logic             at_min,
    output logic             at_max,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] next_number;
    logic             next_dir;
    logic             wrap_next;
    logic             sat_next;
    logic [WIDTH-1:0] load_clamped;
    logic             count_active;

    updown_next_calc #(
        .WIDTH   (WIDTH),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL)
    ) u_next_calc (
        .number      (number),
        .mode        (mode),
        .dir_up      (dir_up),
        .wrap_en     (wrap_en),
        .next_number (next_number),
        .next_dir    (next_dir),
        .wrap_next   (wrap_next),
        .sat_next    (sat_next)
    );

    // Load value clamp and count-enable qualification.
    always_comb begin
        load_clamped = WIDTH'(clamp_bound(32'(load_val), MIN_VAL, MAX_VAL));
        count_active = en && (mode != MODE_HOLD);
    end

    // State update with priority rst > load > enabled count > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            number <= MIN_V;
            dir_up <= ST_UP;
            wrap   <= 1'b0;
            sat    <= 1'b0;
        end else if (load) begin
            number <= load_clamped;
            wrap   <= 1'b0;
            sat    <= 1'b0;
        end else if (count_active) begin
            number <= next_number;
            dir_up <= next_dir;
            wrap   <= wrap_next;
            sat    <= sat_next;
        end else begin
            wrap <= 1'b0;
            sat  <= 1'b0;
        end
    end

    // Status flags decoded directly from the count register.
    always_comb begin
        zero   = (number == '0);
        at_min = (number == MIN_V);
        at_max = (number == MAX_V);
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: a bounded instance (2..9) and a
// default instance (0..15) share stimulus and are checked every cycle
// against a behavioural model, with literal pins on key points.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b11;
    logic       wrap_en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] num_o  [2];
    logic       dir_o  [2];
    logic       zero_o [2];
    logic       min_o  [2];
    logic       max_o  [2];
    logic       wrap_o [2];
    logic       sat_o  [2];

    int vectors = 0;
    int miscompares = 0;
    bit model_valid = 1'b0;

    int m_num  [2];
    bit m_dir  [2];
    bit m_wrap [2];
    bit m_sat  [2];
    int lo [2] = '{2, 0};
    int hi [2] = '{9, 15};

    always #5 clk = ~clk;

    updown_counter_param #(
        .WIDTH   (4),
        .MIN_VAL (2),
        .MAX_VAL (9)
    ) dut (
        .clk (clk), .rst (rst), .en (en), .mode (mode), .wrap_en (wrap_en),
        .load (load), .load_val (load_val),
        .number (num_o[0]), .dir_up (dir_o[0]), .zero (zero_o[0]),
        .at_min (min_o[0]), .at_max (max_o[0]), .wrap (wrap_o[0]), .sat (sat_o[0])
    );

    updown_counter_param dut_def (
        .clk (clk), .rst (rst), .en (en), .mode (mode), .wrap_en (wrap_en),
        .load (load), .load_val (load_val),
        .number (num_o[1]), .dir_up (dir_o[1]), .zero (zero_o[1]),
        .at_min (min_o[1]), .at_max (max_o[1]), .wrap (wrap_o[1]), .sat (sat_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one clock edge for instance k.
    function automatic void model_step(input int k);
        m_wrap[k] = 1'b0;
        m_sat[k]  = 1'b0;
        if (rst) begin
            m_num[k] = lo[k];
            m_dir[k] = 1'b1;
        end else if (load) begin
            m_num[k] = (int'(load_val) < lo[k]) ? lo[k] :
                       (int'(load_val) > hi[k]) ? hi[k] : int'(load_val);
        end else if (en && mode != 2'b11) begin
            if (mode == 2'b01) begin
                m_dir[k] = 1'b1;
                if (m_num[k] < hi[k]) m_num[k] = m_num[k] + 1;
                else if (wrap_en) begin m_num[k] = lo[k]; m_wrap[k] = 1'b1; end
                else m_sat[k] = 1'b1;
            end else if (mode == 2'b00) begin
                m_dir[k] = 1'b0;
                if (m_num[k] > lo[k]) m_num[k] = m_num[k] - 1;
                else if (wrap_en) begin m_num[k] = hi[k]; m_wrap[k] = 1'b1; end
                else m_sat[k] = 1'b1;
            end else if (m_dir[k]) begin
                if (m_num[k] < hi[k]) m_num[k] = m_num[k] + 1;
                else begin m_num[k] = hi[k] - 1; m_dir[k] = 1'b0; m_wrap[k] = 1'b1; end
            end else begin
                if (m_num[k] > lo[k]) m_num[k] = m_num[k] - 1;
                else begin m_num[k] = lo[k] + 1; m_dir[k] = 1'b1; m_wrap[k] = 1'b1; end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        model_valid = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("number[%0d]", k), 32'(num_o[k]), m_num[k]);
                chk($sformatf("dir_up[%0d]", k), 32'(dir_o[k]), 32'(m_dir[k]));
                chk($sformatf("zero[%0d]", k), 32'(zero_o[k]), 32'(m_num[k] == 0));
                chk($sformatf("at_min[%0d]", k), 32'(min_o[k]), 32'(m_num[k] == lo[k]));
                chk($sformatf("at_max[%0d]", k), 32'(max_o[k]), 32'(m_num[k] == hi[k]));
                chk($sformatf("wrap[%0d]", k), 32'(wrap_o[k]), 32'(m_wrap[k]));
                chk($sformatf("sat[%0d]", k), 32'(sat_o[k]), 32'(m_sat[k]));
            end
        end
    end

    initial begin
        // Reset and wrapping up-count 2..9 -> 2.
        rst = 1'b1;
        ticks(2);
        chk("pin_rst_num", 32'(num_o[0]), 2);
        chk("pin_rst_dir", 32'(dir_o[0]), 1);
        chk("pin_rst_def_num", 32'(num_o[1]), 0);
        rst = 1'b0; en = 1'b1; mode = 2'b01; wrap_en = 1'b1;
        ticks(7);
        chk("pin_up_num9", 32'(num_o[0]), 9);
        chk("pin_up_atmax", 32'(max_o[0]), 1);
        chk("pin_up_nowrap", 32'(wrap_o[0]), 0);
        tick();
        chk("pin_up_wrapnum", 32'(num_o[0]), 2);
        chk("pin_up_wrap", 32'(wrap_o[0]), 1);

        // Saturate at 9, then reverse.
        load = 1'b1; load_val = 4'd7; tick();
        load = 1'b0; wrap_en = 1'b0;
        ticks(4);
        chk("pin_sat_num", 32'(num_o[0]), 9);
        chk("pin_sat_flag", 32'(sat_o[0]), 1);
        chk("pin_sat_nowrap", 32'(wrap_o[0]), 0);
        mode = 2'b00; tick();
        chk("pin_sat_down", 32'(num_o[0]), 8);
        chk("pin_sat_clear", 32'(sat_o[0]), 0);

        // Ping-pong from 7 going up.
        load = 1'b1; load_val = 4'd6; tick();
        load = 1'b0; mode = 2'b01; tick();
        mode = 2'b10;
        ticks(3);
        chk("pin_pp_turn_num", 32'(num_o[0]), 8);
        chk("pin_pp_turn_wrap", 32'(wrap_o[0]), 1);
        chk("pin_pp_turn_dir", 32'(dir_o[0]), 0);
        ticks(7);
        chk("pin_pp_bottom_num", 32'(num_o[0]), 3);
        chk("pin_pp_bottom_wrap", 32'(wrap_o[0]), 1);
        chk("pin_pp_bottom_dir", 32'(dir_o[0]), 1);

        // Load clamping and load priority over count.
        load = 1'b1; load_val = 4'd12; tick();
        chk("pin_load_hi", 32'(num_o[0]), 9);
        load_val = 4'd0; tick();
        chk("pin_load_lo", 32'(num_o[0]), 2);
        mode = 2'b01; load_val = 4'd5; tick();
        chk("pin_load_prio", 32'(num_o[0]), 5);

        // Reset during a ping-pong down sweep.
        load_val = 4'd9; tick();
        load = 1'b0; mode = 2'b10;
        ticks(3);
        chk("pin_ppd_num", 32'(num_o[0]), 6);
        chk("pin_ppd_dir", 32'(dir_o[0]), 0);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("pin_mrst_num", 32'(num_o[0]), 2);
        chk("pin_mrst_dir", 32'(dir_o[0]), 1);
        chk("pin_mrst_wrap", 32'(wrap_o[0]), 0);
        chk("pin_mrst_sat", 32'(sat_o[0]), 0);

        // Default bounds: down through zero and wrap to 15, then freeze.
        load = 1'b1; load_val = 4'd1; tick();
        load = 1'b0; mode = 2'b00; wrap_en = 1'b1; tick();
        chk("pin_def_zero_num", 32'(num_o[1]), 0);
        chk("pin_def_zero", 32'(zero_o[1]), 1);
        tick();
        chk("pin_def_wrap_num", 32'(num_o[1]), 15);
        chk("pin_def_wrap", 32'(wrap_o[1]), 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pin_def_en0_num", 32'(num_o[1]), 15);
            chk("pin_def_en0_wrap", 32'(wrap_o[1]), 0);
        end
        en = 1'b1; mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pin_def_hold_num", 32'(num_o[1]), 15);
            chk("pin_def_hold_sat", 32'(sat_o[1]), 0);
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 7) != 0);
            mode     = 2'($urandom_range(0, 3));
            wrap_en  = 1'($urandom_range(0, 1));
            load_val = 4'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
